axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
- Shares the single AXI4 read channel (AR/R) between the icache refill port and the dcache read port.
- Accepts one 128-bit line request or one 32-bit uncached request at a time and issues the AXI burst.
- Assembles the returned beats and returns them as a single-cycle dev_rvalid/dev_rdata response to the granted cache.
- Sits between the two L1 caches and the SoC AXI crossbar; one transaction is outstanding at a time.

Parameters:
IC_ARID, 4'd0, ARID driven for icache transactions
DC_ARID, 4'd1, ARID driven for dcache transactions
RR_EN, 1, 1 = round-robin between the caches; 0 = fixed dcache priority

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active high
ic_ren  in  1  icache read request, level, held until ic_ren_received
ic_raddr  in  32  icache request address, line aligned by arbiter
ic_ren_received  out  1  1-cycle pulse, icache request captured
ic_rvalid  out  1  1-cycle pulse, icache line valid
ic_rdata  out  128  icache line, word k at bits [32k+31:32k]
ic_busy  out  1  icache transaction granted and not yet returned (drives icache flush_flag_valid)
dc_ren  in  1  dcache read request, level
dc_raddr  in  32  dcache request address
dc_uncached  in  1  1 = single 32-bit read at dc_raddr
dc_ren_received  out  1  1-cycle pulse, dcache request captured
dc_rvalid  out  1  1-cycle pulse, dcache data valid
dc_rdata  out  128  line, or {96'b0, word} when uncached
araddr  out  32  AXI AR address
arid  out  4  AXI AR id
arlen  out  8  3 for a line, 0 for uncached
arsize  out  3  constant 3'b010
arburst  out  2  constant 2'b01 (INCR)
arvalid  out  1  AXI AR valid
arready  in  1  AXI AR ready
rid  in  4  AXI R id, not checked
rdata  in  32  AXI R data
rresp  in  2  AXI R response, ignored
rlast  in  1  AXI R last
rvalid  in  1  AXI R valid
rready  out  1  AXI R ready

Behaviour:
- Reset values: all outputs 0, except arsize = 3'b010 and arburst = 2'b01; FSM = IDLE; last_grant = icache (so dcache wins the first tie).
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - If any request is present, grant per arbitration and pulse the granted *_ren_received for 1 cycle, registered, in the cycle the FSM enters ADDR.
  - Latch the owner, uncached flag, ARID and address. Address is {addr[31:4], 4'b0} for a line, addr unchanged for uncached.
  - Icache requests are always line requests.
- Arbitration:
  - Only one requester: grant it.
  - Both, RR_EN = 1: grant the one not granted last.
  - Both, RR_EN = 0: grant dcache.
- ADDR:
  - arvalid = 1; araddr/arid/arlen stay stable while arvalid && !arready.
  - On arready, go to DATA; arvalid = 0 from the next cycle.
- DATA:
  - rready = 1.
  - Each rvalid beat writes rdata into buffer word beat_cnt (2-bit counter from 0, saturates at 3).
  - Uncached: beat 0 goes to word 0, words 1-3 are cleared.
  - On rvalid && rlast, go to RESP. rlast is authoritative; the arlen count is not checked.
- RESP:
  - Pulse the owner's *_rvalid for exactly 1 cycle with the buffer on *_rdata. The non-owner's rvalid stays 0.
  - Update last_grant, then return to IDLE.
  - The rdata outputs hold the last value between responses.
- Latency:
  - ren_received 1 cycle after the request is seen in IDLE.
  - With arready = 1 and back-to-back beats, a line takes 1 (IDLE) + 1 (ADDR) + 4 (DATA) + 1 (RESP) = 7 cycles from request to rvalid.
  - The next grant is evaluated in the IDLE cycle after RESP.
- ic_busy: 1 from the cycle of the icache grant (ic_ren_received) through the RESP cycle; 0 otherwise.
  - The icache uses it to mark an in-flight refill on flush.
  - The arbiter never cancels a transaction: a flushed icache still receives ic_rvalid and discards it itself.
- Requests are sampled only in IDLE. A request deasserted before grant is dropped silently. A request asserted during ADDR/DATA/RESP waits.
- A requester still asserting ren after its own RESP is granted again only per arbitration.
- rst in any state: next cycle FSM = IDLE and arvalid/rready/rvalid outputs = 0. The outstanding burst is abandoned; the interconnect is reset with the same rst.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, ADDR, DATA, RESP).
  - AXI constants: ARSIZE_4B = 3'b010, ARBURST_INCR = 2'b01, LINE_ARLEN = 8'd3.
  - Owner encoding: OWN_IC = 0, OWN_DC = 1.
- One natural sub-module: axi_rd_line_buf, a 4x32 beat assembler with counter, clear and uncached zero-fill. Arbitration and the FSM stay in the top.

Test Plan:
- ic_ren, addr 0x1C00_0024, arready = 1, beats 0x11,0x22,0x33,0x44 -> araddr 0x1C00_0020, arlen 3, arid 0; ic_rvalid at cycle 7; ic_rdata = 0x00000044_00000033_00000022_00000011.
- ic_ren and dc_ren in the same cycle, RR_EN = 1 -> dcache granted first, icache next. Second pair -> icache first. With RR_EN = 0 -> dcache always first.
- dc_uncached, addr 0xBFAF_8004, one beat 0xDEADBEEF -> araddr 0xBFAF_8004, arlen 0; dc_rdata = {96'b0, 32'hDEADBEEF}.
- arready low for 5 cycles, then rvalid gaps between beats -> AR fields stable while waiting; beats land in order; exactly one ic_rvalid pulse.
- ic_busy check -> 1 from grant through RESP; the icache flush mid-burst still gets the ic_rvalid pulse.
- rst asserted during DATA beat 2 -> next cycle IDLE, rready = 0, no rvalid pulse; a new dc_ren is granted normally afterward.

Source files
------------

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the two-cache AXI4 read arbiter: FSM encoding,
// fixed AR-channel constants and owner encoding.
package axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [2:0] ARSIZE_4B    = 3'b010;
  localparam logic [1:0] ARBURST_INCR = 2'b01;
  localparam logic [7:0] LINE_ARLEN   = 8'd3;
  localparam logic [7:0] UNC_ARLEN    = 8'd0;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  // Line requests start on a 16-byte boundary; uncached words keep their address.
  function automatic logic [31:0] ar_addr(input logic [31:0] addr, input logic uncached);
    return uncached ? addr : {addr[31:4], 4'b0000};
  endfunction

endpackage

// File: rtl/axi_rd_line_buf.sv
// 4x32 beat assembler: each write lands in word beat_cnt; an uncached write
// zero-fills the rest of the line. o_line reflects the line including the current beat.
module axi_rd_line_buf
  import axi_rd_arbiter_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clear,
  input  logic         i_wr,
  input  logic         i_uncached,
  input  logic [31:0]  i_wdata,
  output logic [127:0] o_line
);

  logic [127:0] r_line;
  logic [1:0]   r_cnt;
  logic [127:0] w_line_nxt;

  always_comb begin
    w_line_nxt = i_uncached ? '0 : r_line;
    w_line_nxt[{r_cnt, 5'd0} +: 32] = i_wdata;
  end

  assign o_line = w_line_nxt;

  // Beat counter saturates so a long burst keeps overwriting the top word.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cnt <= 2'd0;
    end else if (i_wr && (r_cnt != 2'd3)) begin
      r_cnt <= r_cnt + 2'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_line <= '0;
    end else if (i_wr) begin
      r_line <= w_line_nxt;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read channel between icache refills and dcache reads,
// one outstanding burst at a time, returning a single-cycle assembled response.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter logic [3:0] IC_ARID = 4'd0,
  parameter logic [3:0] DC_ARID = 4'd1,
  parameter bit         RR_EN   = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ic_ren,
  input  logic [31:0]  ic_raddr,
  output logic         ic_ren_received,
  output logic         ic_rvalid,
  output logic [127:0] ic_rdata,
  output logic         ic_busy,
  input  logic         dc_ren,
  input  logic [31:0]  dc_raddr,
  input  logic         dc_uncached,
  output logic         dc_ren_received,
  output logic         dc_rvalid,
  output logic [127:0] dc_rdata,
  output logic [31:0]  araddr,
  output logic [3:0]   arid,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready
);

  state_e       r_state;
  state_e       w_state_nxt;
  logic         r_owner;
  logic         r_unc;
  logic         r_last_grant;
  logic [31:0]  r_araddr;
  logic [3:0]   r_arid;
  logic [7:0]   r_arlen;
  logic         r_ic_ren_received;
  logic         r_dc_ren_received;
  logic         r_ic_rvalid;
  logic         r_dc_rvalid;
  logic [127:0] r_ic_rdata;
  logic [127:0] r_dc_rdata;

  logic         w_gnt_owner;
  logic         w_grant;
  logic         w_gnt_unc;
  logic         w_beat;
  logic         w_last_beat;
  logic [127:0] w_line;
  logic         w_unused;

  // rid and rresp are not used: one burst in flight, errors are not reported.
  assign w_unused = ^{rid, rresp};

  always_comb begin
    w_gnt_owner = OWN_IC;
    if (ic_ren && dc_ren) begin
      w_gnt_owner = RR_EN ? ~r_last_grant : OWN_DC;
    end else if (dc_ren) begin
      w_gnt_owner = OWN_DC;
    end
  end

  assign w_grant     = (r_state == ST_IDLE) && (ic_ren || dc_ren);
  assign w_gnt_unc   = (w_gnt_owner == OWN_DC) && dc_uncached;
  assign w_beat      = (r_state == ST_DATA) && rvalid;
  assign w_last_beat = w_beat && rlast;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_grant) w_state_nxt = ST_ADDR;
      ST_ADDR: if (arready) w_state_nxt = ST_DATA;
      ST_DATA: if (w_last_beat) w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= ST_IDLE;
      r_owner           <= OWN_IC;
      r_unc             <= 1'b0;
      r_last_grant      <= OWN_IC;
      r_araddr          <= '0;
      r_arid            <= '0;
      r_arlen           <= '0;
      r_ic_ren_received <= 1'b0;
      r_dc_ren_received <= 1'b0;
      r_ic_rvalid       <= 1'b0;
      r_dc_rvalid       <= 1'b0;
      r_ic_rdata        <= '0;
      r_dc_rdata        <= '0;
    end else begin
      r_state           <= w_state_nxt;
      r_ic_ren_received <= w_grant && (w_gnt_owner == OWN_IC);
      r_dc_ren_received <= w_grant && (w_gnt_owner == OWN_DC);
      r_ic_rvalid       <= w_last_beat && (r_owner == OWN_IC);
      r_dc_rvalid       <= w_last_beat && (r_owner == OWN_DC);
      if (w_grant) begin
        r_owner  <= w_gnt_owner;
        r_unc    <= w_gnt_unc;
        r_araddr <= ar_addr((w_gnt_owner == OWN_DC) ? dc_raddr : ic_raddr, w_gnt_unc);
        r_arid   <= (w_gnt_owner == OWN_DC) ? DC_ARID : IC_ARID;
        r_arlen  <= w_gnt_unc ? UNC_ARLEN : LINE_ARLEN;
      end
      // Response data is captured with the last beat so it is ready in RESP.
      if (w_last_beat && (r_owner == OWN_IC)) r_ic_rdata <= w_line;
      if (w_last_beat && (r_owner == OWN_DC)) r_dc_rdata <= w_line;
      if (r_state == ST_RESP) r_last_grant <= r_owner;
    end
  end

  axi_rd_line_buf u_line_buf (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_clear    (w_grant),
    .i_wr       (w_beat),
    .i_uncached (r_unc),
    .i_wdata    (rdata),
    .o_line     (w_line)
  );

  assign arvalid         = (r_state == ST_ADDR);
  assign rready          = (r_state == ST_DATA);
  assign araddr          = r_araddr;
  assign arid            = r_arid;
  assign arlen           = r_arlen;
  assign arsize          = ARSIZE_4B;
  assign arburst         = ARBURST_INCR;
  assign ic_ren_received = r_ic_ren_received;
  assign dc_ren_received = r_dc_ren_received;
  assign ic_rvalid       = r_ic_rvalid;
  assign dc_rvalid       = r_dc_rvalid;
  assign ic_rdata        = r_ic_rdata;
  assign dc_rdata        = r_dc_rdata;
  assign ic_busy         = (r_state != ST_IDLE) && (r_owner == OWN_IC);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed scoreboard bench for axi_rd_arbiter: a round-robin and a fixed-priority
// instance share stimulus; sel chooses which one sees requests and is observed.
module tb_axi_rd_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, sel;
  logic ic_ren, dc_ren, dc_uncached;
  logic [31:0] ic_raddr, dc_raddr, rdata;
  logic arready, rvalid, rlast;
  logic [3:0] rid;
  logic [1:0] rresp;

  logic a_ic_rcv, a_ic_rvalid, a_ic_busy, a_dc_rcv, a_dc_rvalid, a_arvalid, a_rready;
  logic b_ic_rcv, b_ic_rvalid, b_ic_busy, b_dc_rcv, b_dc_rvalid, b_arvalid, b_rready;
  logic [127:0] a_ic_rdata, a_dc_rdata, b_ic_rdata, b_dc_rdata;
  logic [31:0] a_araddr, b_araddr;
  logic [3:0] a_arid, b_arid;
  logic [7:0] a_arlen, b_arlen;
  logic [2:0] a_arsize, b_arsize;
  logic [1:0] a_arburst, b_arburst;

  axi_rd_arbiter #(.IC_ARID(4'd0), .DC_ARID(4'd1), .RR_EN(1'b1)) u_rr (
    .clk(clk), .rst(rst),
    .ic_ren(ic_ren & ~sel), .ic_raddr(ic_raddr), .ic_ren_received(a_ic_rcv),
    .ic_rvalid(a_ic_rvalid), .ic_rdata(a_ic_rdata), .ic_busy(a_ic_busy),
    .dc_ren(dc_ren & ~sel), .dc_raddr(dc_raddr), .dc_uncached(dc_uncached),
    .dc_ren_received(a_dc_rcv), .dc_rvalid(a_dc_rvalid), .dc_rdata(a_dc_rdata),
    .araddr(a_araddr), .arid(a_arid), .arlen(a_arlen), .arsize(a_arsize),
    .arburst(a_arburst), .arvalid(a_arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(a_rready)
  );

  axi_rd_arbiter #(.IC_ARID(4'd0), .DC_ARID(4'd1), .RR_EN(1'b0)) u_fix (
    .clk(clk), .rst(rst),
    .ic_ren(ic_ren & sel), .ic_raddr(ic_raddr), .ic_ren_received(b_ic_rcv),
    .ic_rvalid(b_ic_rvalid), .ic_rdata(b_ic_rdata), .ic_busy(b_ic_busy),
    .dc_ren(dc_ren & sel), .dc_raddr(dc_raddr), .dc_uncached(dc_uncached),
    .dc_ren_received(b_dc_rcv), .dc_rvalid(b_dc_rvalid), .dc_rdata(b_dc_rdata),
    .araddr(b_araddr), .arid(b_arid), .arlen(b_arlen), .arsize(b_arsize),
    .arburst(b_arburst), .arvalid(b_arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(b_rready)
  );

  logic o_ic_rcv, o_ic_rvalid, o_ic_busy, o_dc_rcv, o_dc_rvalid, o_arvalid, o_rready;
  logic [127:0] o_ic_rdata, o_dc_rdata;
  logic [31:0] o_araddr;
  logic [3:0] o_arid;
  logic [7:0] o_arlen;
  logic [2:0] o_arsize;
  logic [1:0] o_arburst;

  assign o_ic_rcv    = sel ? b_ic_rcv    : a_ic_rcv;
  assign o_ic_rvalid = sel ? b_ic_rvalid : a_ic_rvalid;
  assign o_ic_busy   = sel ? b_ic_busy   : a_ic_busy;
  assign o_dc_rcv    = sel ? b_dc_rcv    : a_dc_rcv;
  assign o_dc_rvalid = sel ? b_dc_rvalid : a_dc_rvalid;
  assign o_arvalid   = sel ? b_arvalid   : a_arvalid;
  assign o_rready    = sel ? b_rready    : a_rready;
  assign o_ic_rdata  = sel ? b_ic_rdata  : a_ic_rdata;
  assign o_dc_rdata  = sel ? b_dc_rdata  : a_dc_rdata;
  assign o_araddr    = sel ? b_araddr    : a_araddr;
  assign o_arid      = sel ? b_arid      : a_arid;
  assign o_arlen     = sel ? b_arlen     : a_arlen;
  assign o_arsize    = sel ? b_arsize    : a_arsize;
  assign o_arburst   = sel ? b_arburst   : a_arburst;

  typedef struct packed {
    logic [31:0]  addr;
    logic [3:0]   id;
    logic [7:0]   len;
    logic [127:0] beats;
    logic [2:0]   n;
  } ar_t;

  typedef struct packed {
    logic         own;
    logic [127:0] data;
    logic [31:0]  t_req;
    logic [31:0]  lat;
  } rs_t;

  ar_t ar_q[$];
  rs_t rs_q[$];
  logic [31:0] beat_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int ar_wait_cfg = 0;
  int gap_cfg = 0;
  int wait_cnt = 0;
  int gap_cnt = 0;
  int sent = 0;
  bit ic_inflight = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_req(input logic own, input logic [31:0] addr, input logic unc,
                          input logic [127:0] beats, input int lat);
    ar_t a;
    rs_t r;
    a.addr  = unc ? addr : {addr[31:4], 4'h0};
    a.id    = own ? 4'd1 : 4'd0;
    a.len   = unc ? 8'd0 : 8'd3;
    a.beats = beats;
    a.n     = unc ? 3'd1 : 3'd4;
    r.own   = own;
    r.data  = unc ? {96'h0, beats[31:0]} : beats;
    r.t_req = 32'(cyc);
    r.lat   = 32'(lat);
    ar_q.push_back(a);
    rs_q.push_back(r);
  endtask

  task automatic issue_ic(input logic [31:0] addr, input logic [127:0] beats, input int lat);
    push_req(1'b0, addr, 1'b0, beats, lat);
    ic_raddr = addr;
    ic_ren = 1'b1;
  endtask

  task automatic issue_dc(input logic [31:0] addr, input logic unc, input logic [127:0] beats);
    push_req(1'b1, addr, unc, beats, 0);
    dc_raddr = addr;
    dc_uncached = unc;
    dc_ren = 1'b1;
  endtask

  task automatic issue_pair(input bit dc_first, input logic [31:0] ia, input logic [127:0] ib,
                            input logic [31:0] da, input logic [127:0] db);
    if (dc_first) begin
      push_req(1'b1, da, 1'b0, db, 0);
      push_req(1'b0, ia, 1'b0, ib, 0);
    end else begin
      push_req(1'b0, ia, 1'b0, ib, 0);
      push_req(1'b1, da, 1'b0, db, 0);
    end
    ic_raddr = ia;
    dc_raddr = da;
    dc_uncached = 1'b0;
    ic_ren = 1'b1;
    dc_ren = 1'b1;
  endtask

  // One clock: check outputs at the falling edge, then drive the AXI slave side.
  task automatic cycle();
    ar_t a;
    rs_t r;
    @(negedge clk);
    cyc++;
    chk("ic_busy", 128'(o_ic_busy), 128'(ic_inflight | o_ic_rcv));
    if (o_ic_rcv || o_dc_rcv) chk("single_grant", 128'(o_ic_rcv & o_dc_rcv), 128'(0));
    if (o_ic_rcv) begin
      chk("ic_rcv_req", 128'(ic_ren), 128'(1));
      ic_ren = 1'b0;
      ic_inflight = 1'b1;
    end
    if (o_dc_rcv) begin
      chk("dc_rcv_req", 128'(dc_ren), 128'(1));
      dc_ren = 1'b0;
      dc_uncached = 1'b0;
    end
    if (o_ic_rvalid || o_dc_rvalid) begin
      if (rs_q.size() == 0) begin
        chk("spurious_rvalid", 128'({o_ic_rvalid, o_dc_rvalid}), 128'(0));
      end else begin
        r = rs_q.pop_front();
        chk("rvalid_owner", 128'({o_ic_rvalid, o_dc_rvalid}), r.own ? 128'(2'b01) : 128'(2'b10));
        chk("rdata", r.own ? o_dc_rdata : o_ic_rdata, r.data);
        if (r.lat != 0) chk("latency", 128'(32'(cyc) - r.t_req + 32'd1), 128'(r.lat));
      end
    end
    if (o_ic_rvalid) ic_inflight = 1'b0;
    if (o_arvalid) begin
      if (ar_q.size() == 0) begin
        chk("spurious_arvalid", 128'(o_arvalid), 128'(0));
        arready = 1'b0;
      end else begin
        a = ar_q[0];
        chk("araddr", 128'(o_araddr), 128'(a.addr));
        chk("arid", 128'(o_arid), 128'(a.id));
        chk("arlen", 128'(o_arlen), 128'(a.len));
        if (wait_cnt >= ar_wait_cfg) begin
          arready = 1'b1;
          void'(ar_q.pop_front());
          for (int i = 0; i < int'(a.n); i++) beat_q.push_back(a.beats[32*i +: 32]);
          wait_cnt = 0;
          gap_cnt = 0;
        end else begin
          arready = 1'b0;
          wait_cnt++;
        end
      end
    end else begin
      arready = 1'b0;
    end
    rvalid = 1'b0;
    rlast = 1'b0;
    rdata = 32'hBAD0_0000 | 32'(cyc);
    if (o_rready && beat_q.size() > 0) begin
      if (gap_cnt > 0) begin
        gap_cnt--;
      end else begin
        rdata = beat_q.pop_front();
        rvalid = 1'b1;
        rlast = (beat_q.size() == 0);
        sent++;
        gap_cnt = gap_cfg;
      end
    end
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((rs_q.size() != 0 || ar_q.size() != 0 || ic_ren || dc_ren) && n < max) begin
      cycle();
      n++;
    end
    chk("drain_timeout", 128'(n < max), 128'(1));
    if (n >= max) begin
      rs_q.delete(); ar_q.delete(); beat_q.delete();
      ic_ren = 1'b0; dc_ren = 1'b0;
    end
    cycle();
    cycle();
  endtask

  initial begin
    int n;
    rst = 1'b1; sel = 1'b0;
    ic_ren = 1'b0; dc_ren = 1'b0; dc_uncached = 1'b0;
    ic_raddr = '0; dc_raddr = '0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rid = '0; rresp = '0;
    cycle();
    cycle();
    chk("rst_arvalid", 128'(o_arvalid), 128'(0));
    chk("rst_rready", 128'(o_rready), 128'(0));
    chk("rst_arsize", 128'(o_arsize), 128'(3'b010));
    chk("rst_arburst", 128'(o_arburst), 128'(2'b01));
    chk("rst_araddr", 128'(o_araddr), 128'(0));
    chk("rst_arlen", 128'(o_arlen), 128'(0));
    chk("rst_ic_rdata", o_ic_rdata, 128'(0));
    chk("rst_dc_rdata", o_dc_rdata, 128'(0));
    chk("rst_pulses", 128'({o_ic_rcv, o_dc_rcv, o_ic_rvalid, o_dc_rvalid}), 128'(0));
    rst = 1'b0;
    cycle();

    // Single icache line, back-to-back beats, 7-cycle latency.
    issue_ic(32'h1C00_0024, 128'h00000044_00000033_00000022_00000011, 7);
    drain(100);

    // Round robin: first tie goes to dcache, then icache.
    issue_pair(1'b1, 32'h1C00_0100, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0,
               32'h2000_004C, 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0);
    drain(200);
    issue_dc(32'h2000_0080, 1'b0, 128'h13131313_12121212_11111111_10101010);
    drain(100);
    issue_pair(1'b0, 32'h1C00_0200, 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0,
               32'h2000_00C0, 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0);
    drain(200);

    // Uncached single word after a dcache line: upper words must read zero.
    issue_dc(32'hBFAF_8004, 1'b1, 128'hFFFFFFFF_EEEEEEEE_CAFEF00D_DEADBEEF);
    drain(100);

    // AR stall for 5 cycles, then gaps between beats.
    ar_wait_cfg = 5;
    gap_cfg = 2;
    issue_ic(32'h0000_1238, 128'h40404040_30303030_20202020_10101010, 0);
    drain(200);
    ar_wait_cfg = 0;

    // Icache flushed mid-burst: still busy and still gets its response.
    gap_cfg = 3;
    sent = 0;
    issue_ic(32'h0000_4000, 128'h88888888_77777777_66666666_55555555, 0);
    n = 0;
    while (sent < 2 && n < 100) begin cycle(); n++; end
    chk("flush_reach_beat", 128'(sent >= 2), 128'(1));
    chk("busy_midburst", 128'(o_ic_busy), 128'(1));
    drain(200);
    gap_cfg = 0;

    // Reset during the third beat abandons the burst.
    sent = 0;
    issue_dc(32'h3000_0010, 1'b0, 128'h04040404_03030303_02020202_01010101);
    n = 0;
    while (sent < 3 && n < 100) begin cycle(); n++; end
    chk("rst_reach_beat", 128'(sent), 128'(3));
    rst = 1'b1;
    ar_q.delete(); rs_q.delete(); beat_q.delete();
    ic_inflight = 1'b0;
    cycle();
    chk("rst_mid_rready", 128'(o_rready), 128'(0));
    chk("rst_mid_arvalid", 128'(o_arvalid), 128'(0));
    chk("rst_mid_rvalid", 128'({o_ic_rvalid, o_dc_rvalid}), 128'(0));
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    issue_dc(32'h3000_0020, 1'b0, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A);
    drain(100);

    // Fixed-priority instance: dcache wins the tie even right after a dcache grant.
    sel = 1'b1;
    cycle();
    issue_dc(32'h2000_0100, 1'b0, 128'h5A5A5A5A_4A4A4A4A_3A3A3A3A_2A2A2A2A);
    drain(100);
    issue_pair(1'b1, 32'h1C00_0300, 128'hE3E3E3E3_E2E2E2E2_E1E1E1E1_E0E0E0E0,
               32'h2000_0140, 128'hF3F3F3F3_F2F2F2F2_F1F1F1F1_F0F0F0F0);
    drain(200);

    chk("scoreboard_empty", 128'(rs_q.size() + ar_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
